// File: rtl/demux_1xn_hs.sv
// demux_1xn_hs
// Parametrised 1-to-NUM_CH demultiplexer with one registered holding stage.
// Each word is routed to exactly one consumer using per-channel valid/ready.
// A word whose select is out of range is dropped and flagged.
//
// Parameters:
//   SEL_W  - select width in bits
//   NUM_CH - number of output channels (2 .. 2**SEL_W)
//   DATA_W - payload width
//   CNT_W  - drop counter width (only used with DEMUX_DROP_CNT_EN)
//
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   in_valid    - producer has a word
//   in_ready    - block can accept a word this cycle
//   in_sel      - destination channel of the input word
//   in_data     - input payload
//   out_valid   - one-hot (or zero) per-channel valid
//   out_ready   - per-channel consumer ready
//   out_data    - payload shared by all channels
//   busy        - holding register occupied
//   drop_pulse  - one-cycle registered pulse per dropped word
//   drop_cnt    - saturating dropped-word count (DEMUX_DROP_CNT_EN only)
//
// Optional feature macro: DEMUX_DROP_CNT_EN enables the drop_cnt port.
module demux_1xn_hs #(
  parameter int SEL_W  = 2,
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
`ifdef DEMUX_DROP_CNT_EN
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_cnt
`else
  output logic              drop_pulse
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // Channel count widened by one bit so the comparison stays unsigned and
  // still works when NUM_CH equals 2**SEL_W (every select is in range then).
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  state_t              state_q;
  state_t              state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   data_q;
  logic                in_range;
  logic                drain;
  logic                accept;
  logic                load;
  logic                drop;

  // Output decode, handshake and next-state logic.
  // The drain check only looks at the ready bit of the channel holding the
  // word, since out_valid masks every other channel.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_valid[k] = (state_q == FULL) && (sel_q == SEL_W'(k));
    end
    in_range = ({1'b0, in_sel} < NUM_CH_L);
    drain    = |(out_valid & out_ready);
    in_ready = (state_q == IDLE) || drain;
    accept   = in_valid && in_ready;
    load     = accept && in_range;
    drop     = accept && !in_range;

    state_d = state_q;
    if (load) begin
      state_d = FULL;
    end else if (drain) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding register: reloads on any in-range accept, including the cycle
  // the previous word drains, so there is no bubble between words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      data_q <= '0;
    end else if (load) begin
      sel_q  <= in_sel;
      data_q <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

  assign out_data = data_q;
  assign busy     = (state_q == FULL);

endmodule

// File: tb/tb_demux_1xn_hs.sv
// tb_demux_1xn_hs
// Self-checking bench for demux_1xn_hs, built with SEL_W=2 and NUM_CH=3 so
// select 3 is out of range, and CNT_W=2 so the drop counter saturates at 3.
// A one-entry scoreboard queue holds the word the DUT should be presenting.
module tb_demux_1xn_hs;

  localparam int SEL_W  = 2;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [DATA_W-1:0] in_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              drop_pulse;
`ifdef DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0]  drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {sel, data}
  logic [SEL_W+DATA_W-1:0] sb_q[$];
  logic                    exp_drop;
  int                      exp_cnt;

  demux_1xn_hs #(
    .SEL_W (SEL_W),
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
`ifdef DEMUX_DROP_CNT_EN
    .drop_pulse(drop_pulse),
    .drop_cnt  (drop_cnt)
`else
    .drop_pulse(drop_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reset-state checks shared by power-on and mid-transfer reset.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    checkOutput({tag, "_drop_pulse"}, 32'(drop_pulse), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
`endif
  endtask

  // Drives one cycle at posedge+1, checks at the following negedge against
  // the scoreboard, then advances the model across the next rising edge.
  task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                               input logic [DATA_W-1:0] d,
                               input logic [NUM_CH-1:0] r);
    logic [NUM_CH-1:0] exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ready;
    logic              acc;
    logic              drn;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    exp_valid = '0;
    exp_data  = '0;
    drn       = 1'b0;
    if (sb_q.size() != 0) begin
      exp_valid = NUM_CH'(1) << sb_q[0][SEL_W+DATA_W-1:DATA_W];
      exp_data  = sb_q[0][DATA_W-1:0];
      drn       = r[sb_q[0][SEL_W+DATA_W-1:DATA_W]];
    end
    exp_ready = (sb_q.size() == 0) || drn;
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    if (sb_q.size() != 0) checkOutput("out_data", 32'(out_data), 32'(exp_data));
    checkOutput("busy", 32'(busy), 32'(sb_q.size() != 0));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
`ifdef DEMUX_DROP_CNT_EN
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(exp_cnt));
`endif
    acc = v && exp_ready;
    if (drn) void'(sb_q.pop_front());
    exp_drop = 1'b0;
    if (acc) begin
      if (int'(s) < NUM_CH) begin
        sb_q.push_back({s, d});
      end else begin
        exp_drop = 1'b1;
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    exp_drop  = 1'b0;
    exp_cnt   = 0;
    #12;
    checkResetValues("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Routing: consecutive words to each channel with all consumers ready.
    for (int i = 0; i < NUM_CH; i++) begin
      applyStimulus(1'b1, SEL_W'(i), DATA_W'(8'hA0 + i), '1);
    end
    applyStimulus(1'b0, '0, '0, '1);

    // Backpressure on channel 2, other channels' ready toggling ignored.
    applyStimulus(1'b1, 2'd2, 8'h5C, 3'b000);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b011);
    applyStimulus(1'b1, 2'd1, 8'hEE, 3'b001);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b010);
    applyStimulus(1'b1, 2'd0, 8'h11, 3'b100);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);

    // Single drop.
    applyStimulus(1'b1, 2'd3, 8'hD0, 3'b111);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);

    // Five back-to-back drops saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd3, DATA_W'(i), 3'b000);
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);

    // Drain on channel 1 in the same cycle as a drop.
    applyStimulus(1'b1, 2'd1, 8'h77, 3'b000);
    applyStimulus(1'b1, 2'd3, 8'h99, 3'b010);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 3)),
                    DATA_W'($urandom), NUM_CH'($urandom_range(0, 7)));
    end

    // Mid-transfer reset: hold a word, then reset between edges.
    applyStimulus(1'b1, 2'd1, 8'h33, 3'b000);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    sb_q.delete();
    exp_drop = 1'b0;
    exp_cnt  = 0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'd0, 8'h42, 3'b001);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1xn_hs.md
# demux_1xn_hs

Parametrised 1-to-N demultiplexer with a one-entry registered output stage and per-channel valid/ready handshake. Generalises the 2-to-4 decoder to a SEL_W-bit select, NUM_CH channels and DATA_W-bit payload. Sits between a single producer and NUM_CH consumers and routes each accepted word to exactly one consumer. Out-of-range selects are dropped and flagged.

## Interface
- SEL_W, 2: select width in bits.
- NUM_CH, 4: number of output channels; legal range 2..2^SEL_W.
- DATA_W, 8: payload width.
- CNT_W, 8: drop counter width; used only when DEMUX_DROP_CNT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept this cycle.
- in_sel  in  SEL_W  destination channel.
- in_data  in  DATA_W  payload.
- out_valid  out  NUM_CH  one-hot or zero; bit k set means channel k holds a word.
- out_ready  in  NUM_CH  per-channel consumer ready.
- out_data  out  DATA_W  payload shared by all channels, valid where out_valid is set.
- busy  out  1  holding register occupied; equals |out_valid.
- drop_pulse  out  1  one-cycle pulse, registered, one cycle after an out-of-range word is accepted.
- drop_cnt  out  CNT_W  saturating count of dropped words; present only with DEMUX_DROP_CNT_EN.

## Operation
- FSM with 2 states: IDLE (register empty) and FULL (register holds word for channel sel_q).
- in_ready = (state==IDLE) || out_ready[sel_q]. Combinational path from out_ready to in_ready is intentional and gives 1 word/cycle throughput.
- Accept: in_valid && in_ready.
- Accept, in_sel < NUM_CH: load data_q <= in_data, sel_q <= in_sel, state <= FULL.
- Accept, in_sel >= NUM_CH: word discarded, register not loaded, drop_pulse asserted next cycle. If FULL and drained the same cycle, state <= IDLE.
- Drain: state==FULL && out_ready[sel_q]. No new in-range accept the same cycle: state <= IDLE.
- Drain and in-range accept in the same cycle: the register reloads and state stays FULL. No bubble.
- out_valid[k] = (state==FULL) && (sel_q==k). Never more than one bit set.
- out_ready bits of non-selected channels are ignored.
- out_data and out_valid hold stable while FULL and not drained.
- in_valid low: no state change except a drain.
- Select comparison is unsigned. When NUM_CH==2^SEL_W, no select is out of range.

## Timing
- Reset (async assert, sync release at clk edge) values:
  - state=IDLE, out_valid=0, out_data=0, sel_q=0, busy=0.
  - drop_pulse=0, drop_cnt=0.
  - in_ready=1 immediately after reset.
- Latency: word accepted at edge n appears on out_valid/out_data after edge n, so it is visible in cycle n+1.
- Throughput: one word per cycle while the selected consumer keeps ready high.
- Reset asserted mid-transfer: held word is lost; outputs return to reset values asynchronously.
- Back-to-back words to different channels: out_valid moves one-hot between channels on consecutive cycles, with no gap cycle.
- drop_pulse is high for exactly one cycle per dropped word. Consecutive drops produce consecutive high cycles.

## Configuration
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - drop_cnt port exists.
  - Increments by 1 on each out-of-range accept.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- Undefined: the drop_cnt port and its register are absent. Drop behaviour and drop_pulse are unchanged.

## Test plan
- Reset: assert rst mid-cycle with a word held. Expect out_valid=0, out_data=0, busy=0 and in_ready=1 without a clock edge.
- Routing: with all out_ready=1, send in_sel=0..3 with in_data=0xA0..0xA3 on consecutive cycles. Expect out_valid=0001,0010,0100,1000 one cycle later, each with the matching out_data, and in_ready held at 1.
- Backpressure: send sel=2, data=0x5C with out_ready[2]=0 for 3 cycles. Expect out_valid=0100 and out_data=0x5C stable, in_ready=0, and out_ready toggling on other channels ignored. Raise out_ready[2]. Expect release plus same-cycle accept of the next word.
- Drop: NUM_CH=3, SEL_W=2. Send sel=3. Expect no out_valid and drop_pulse=1 for one cycle. With the macro defined, drop_cnt=1.
- Saturation (macro defined, CNT_W=2): send 5 out-of-range words. Expect drop_cnt to saturate at 3 and 5 drop_pulse cycles.
- Simultaneous drain plus drop: FULL on channel 1 with out_ready[1]=1, input sel out of range. Expect FULL to drain to IDLE, busy=0, and drop_pulse=1.
